seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Sequential radix-2 restoring divider, the inverse of the shift-add multiplier datapath.
//  Takes a 2*LENGTH-bit dividend (multiplier product width) and a LENGTH-bit divisor.
//  Produces one quotient bit per clock. Returns a LENGTH-bit quotient and remainder.
//  Sits beside the multiplier in the arithmetic unit and uses the same start/done handshake.
// PARAMETERS
//  LENGTH   16   operand width; quotient/remainder width; dividend is 2*LENGTH
// PORTS
//  clk        in   1          single clock, all state on posedge
//  rst_n      in   1          asynchronous, active-low reset
//  start      in   1          request; sampled only in IDLE
//  dividend   in   2*LENGTH   captured on accepted start
//  divisor    in   LENGTH     captured on accepted start
//  quotient   out  LENGTH     result, valid from done, held until next accepted start
//  remainder  out  LENGTH     result, same validity as quotient
//  busy       out  1          high in RUN and DONE (and FIX when SEQ_DIV_SIGNED_EN is defined)
//  done       out  1          one-cycle pulse, results valid
//  dbz        out  1          divide-by-zero flag, same validity as quotient
//  ovf        out  1          quotient-overflow flag, same validity as quotient
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; internal registers 0. Applies at any time, including mid-RUN.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: if start=1, latch operands and clear flags. Otherwise hold outputs.
//  - Error bypass on the start cycle: divisor==0 sets dbz=1; else dividend[2L-1:L] >= divisor sets ovf=1.
//    Either error goes straight to DONE with quotient={LENGTH{1}} and remainder=0.
//  - RUN: LENGTH iterations, MSB first, using partial remainder r (LENGTH+1 bits, starts at dividend[2L-1:L]).
//    - t = {r[L-1:0], next dividend bit}.
//    - If t >= divisor: r = t - divisor, qbit = 1. Else r = t, qbit = 0.
//    - qbit shifts into the quotient LSB. Iteration counter counts 0..LENGTH-1.
//  - DONE: done=1 for exactly one cycle, then return to IDLE.
//  Latency: start accepted in cycle 0.
//  - Normal operation: done in cycle LENGTH+1.
//  - Error case: done in cycle 1.
//  start while busy=1 is ignored (no queueing). start in the same cycle as done is ignored.
//  A new start may be accepted in the cycle after done.
//  Outputs update only in the DONE-entry cycle. They are never partially visible.
//  Result invariant when dbz=ovf=0: dividend == quotient*divisor + remainder, remainder < divisor.
// CONFIGURATION
//  SEQ_DIV_SIGNED_EN defined:
//  - Adds input port signed_op (1 bit, sampled with start). signed_op=1 treats all operands as two's complement.
//  - Magnitudes are taken at load; the core runs unsigned.
//  - A FIX state is inserted between RUN and DONE. It negates the quotient if the operand signs differ.
//    The remainder takes the dividend's sign.
//  - Latency becomes LENGTH+2.
//  - Signed ovf: |dividend|[2L-1:L-1] >= |divisor|. This check is conservative: quotient magnitude must fit LENGTH-1 bits.
//  - signed_op=0 behaves exactly as the unsigned build, including the unsigned latency of LENGTH+1.
//  SEQ_DIV_SIGNED_EN undefined: unsigned only; no signed_op port; no FIX state.
// STRUCTURE
//  Shared package seq_div_pkg holds:
//  - state encodings IDLE/RUN/FIX/DONE (2-bit);
//  - default LENGTH;
//  - counter width function clog2(LENGTH).
//  One sub-module, seq_div_step: combinational compare-subtract for one iteration.
//  - Inputs: t (LENGTH+1 bits), divisor.
//  - Outputs: r_next, qbit.
//  - Built on the ripple adder style with carry-out as the compare.
//  Top holds the FSM, counter, operand/shift registers and output registers.
// TESTING (LENGTH=16)
//  1. dividend=32'd1000, divisor=16'd7 -> quotient=142, remainder=6, dbz=ovf=0, done in cycle 17.
//  2. divisor=0, any dividend -> dbz=1, quotient=16'hFFFF, remainder=0, done in cycle 1.
//  3. dividend=32'h0001_0000, divisor=16'h0001 -> ovf=1, quotient=16'hFFFF, done in cycle 1.
//  4. dividend=32'hFFFE_0001, divisor=16'hFFFF -> quotient=16'hFFFF, remainder=0, ovf=0.
//  5. Pulse start during RUN -> ignored. Then drop rst_n in cycle 8 -> busy=done=0 and all outputs 0
//     immediately. Next start completes normally.
//  6. SEQ_DIV_SIGNED_EN: signed_op=1, dividend=-1000, divisor=7 -> quotient=16'hFF72, remainder=16'hFFFA,
//     done in cycle 18.
//  Plus random unsigned sweep checked against the result invariant and the flag rules.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Latency: n/a (package only).
// Backpressure: n/a.
// Holds the FSM state encoding, the default operand width and a ceil-log2 helper
// used to size the iteration counter.
package seq_div_pkg;

  // Default operand width; the dividend is twice this wide.
  localparam int SEQ_DIV_LENGTH = 16;

  // FIX is only reachable when the signed build option is compiled in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } seq_div_state_e;

  // Smallest w with 2**w >= n.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: compare-and-subtract of the shifted partial remainder.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports:
//   t       in  LENGTH+1  shifted partial remainder {r[L-1:0], next dividend bit}
//   divisor in  LENGTH    divisor magnitude
//   r_next  out LENGTH+1  t - divisor when t >= divisor, else t
//   qbit    out 1         quotient bit (1 when the subtraction was taken)
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int LENGTH = SEQ_DIV_LENGTH
) (
  input  logic [LENGTH:0]   t,
  input  logic [LENGTH-1:0] divisor,
  output logic [LENGTH:0]   r_next,
  output logic              qbit
);

  // t + ~divisor + 1 as a ripple chain; the final carry-out is set exactly when
  // no borrow occurred, i.e. t >= divisor, so it doubles as the comparator.
  logic [LENGTH:0]   b_inv;
  logic [LENGTH:0]   diff;
  logic [LENGTH+1:0] carry;

  assign b_inv    = ~{1'b0, divisor};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= LENGTH; i++) begin : g_fa
    assign diff[i]      = t[i] ^ b_inv[i] ^ carry[i];
    assign carry[i + 1] = (t[i] & b_inv[i]) | (carry[i] & (t[i] ^ b_inv[i]));
  end

  assign qbit   = carry[LENGTH+1];
  assign r_next = qbit ? diff : t;

endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider: 2*LENGTH-bit dividend / LENGTH-bit divisor.
// Latency: done pulses LENGTH+1 cycles after an accepted start (1 cycle for dbz/ovf, LENGTH+2 for signed ops).
// Backpressure: start is only sampled in IDLE; start while busy or during done is dropped, never queued.
// Build option: define SEQ_DIV_SIGNED_EN to add the signed_op port and the FIX sign-correction state.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start               request, sampled in IDLE only
//   signed_op           (SEQ_DIV_SIGNED_EN only) treat operands as two's complement
//   dividend, divisor   operands, captured on an accepted start
//   quotient, remainder results, written on DONE entry and held until the next result
//   busy                high whenever not IDLE
//   done                one-cycle pulse, results valid
//   dbz, ovf            divide-by-zero / quotient-overflow flags, cleared on accepted start
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int LENGTH = SEQ_DIV_LENGTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic                  signed_op,
`endif
  input  logic [2*LENGTH-1:0]   dividend,
  input  logic [LENGTH-1:0]     divisor,
  output logic [LENGTH-1:0]     quotient,
  output logic [LENGTH-1:0]     remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  dbz,
  output logic                  ovf
);

  localparam int CNT_W = (clog2(LENGTH) < 1) ? 1 : clog2(LENGTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LENGTH - 1);

  seq_div_state_e          state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LENGTH:0]         r_q, r_d;       // partial remainder
  logic [LENGTH-1:0]       dl_q, dl_d;     // dividend bits still to be shifted in
  logic [LENGTH-1:0]       dvs_q, dvs_d;   // divisor magnitude
  logic [LENGTH-1:0]       qs_q, qs_d;     // quotient shift register
  logic [LENGTH-1:0]       quot_q, quot_d;
  logic [LENGTH-1:0]       rem_q, rem_d;
  logic                    dbz_q, dbz_d;
  logic                    ovf_q, ovf_d;
`ifdef SEQ_DIV_SIGNED_EN
  logic                    sgn_q, sgn_d;   // operation needs the FIX pass
  logic                    qneg_q, qneg_d; // operand signs differ
  logic                    rneg_q, rneg_d; // dividend was negative
  logic                    ld_qneg, ld_rneg;
`endif

  // Load-time operand preparation.
  logic [2*LENGTH-1:0]     dvd_mag;
  logic [LENGTH-1:0]       dvs_mag;
  logic                    ovf_chk;

  // Iteration datapath.
  logic [LENGTH:0]         step_t;
  logic [LENGTH:0]         step_r;
  logic                    step_qbit;
  logic [LENGTH-1:0]       qs_nxt;

  // The partial remainder never exceeds the divisor, so its top bit stays clear;
  // it is kept only so the register matches the step width.
  logic                    r_msb_unused;
  assign r_msb_unused = r_q[LENGTH];

  assign step_t = {r_q[LENGTH-1:0], dl_q[LENGTH-1]};
  assign qs_nxt = {qs_q[LENGTH-2:0], step_qbit};

  seq_div_step #(
    .LENGTH (LENGTH)
  ) u_step (
    .t       (step_t),
    .divisor (dvs_q),
    .r_next  (step_r),
    .qbit    (step_qbit)
  );

  // Operand magnitudes and the overflow screen. The core always runs unsigned;
  // a signed request is reduced to magnitudes here and sign-fixed afterwards.
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    ovf_chk = (dividend[2*LENGTH-1:LENGTH] >= divisor);
`ifdef SEQ_DIV_SIGNED_EN
    ld_qneg = 1'b0;
    ld_rneg = 1'b0;
    if (signed_op) begin
      ld_rneg = dividend[2*LENGTH-1];
      ld_qneg = dividend[2*LENGTH-1] ^ divisor[LENGTH-1];
      if (dividend[2*LENGTH-1]) dvd_mag = -dividend;
      if (divisor[LENGTH-1])    dvs_mag = -divisor;
      // Quotient magnitude must leave room for the sign bit, so test one bit lower.
      ovf_chk = (dvd_mag[2*LENGTH-1:LENGTH-1] >= {1'b0, dvs_mag});
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    dl_d    = dl_q;
    dvs_d   = dvs_q;
    qs_d    = qs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
`ifdef SEQ_DIV_SIGNED_EN
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          cnt_d = '0;
          qs_d  = '0;
          dvs_d = dvs_mag;
          r_d   = {1'b0, dvd_mag[2*LENGTH-1:LENGTH]};
          dl_d  = dvd_mag[LENGTH-1:0];
`ifdef SEQ_DIV_SIGNED_EN
          sgn_d  = signed_op;
          qneg_d = ld_qneg;
          rneg_d = ld_rneg;
`endif
          if (divisor == '0) begin
            dbz_d   = 1'b1;
            quot_d  = '1;
            rem_d   = '0;
            state_d = DONE;
          end else if (ovf_chk) begin
            ovf_d   = 1'b1;
            quot_d  = '1;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        r_d   = step_r;
        dl_d  = {dl_q[LENGTH-2:0], 1'b0};
        qs_d  = qs_nxt;
        if (cnt_q == CNT_LAST) begin
`ifdef SEQ_DIV_SIGNED_EN
          if (sgn_q) begin
            state_d = FIX;
          end else begin
            quot_d  = qs_nxt;
            rem_d   = step_r[LENGTH-1:0];
            state_d = DONE;
          end
`else
          quot_d  = qs_nxt;
          rem_d   = step_r[LENGTH-1:0];
          state_d = DONE;
`endif
        end
      end

`ifdef SEQ_DIV_SIGNED_EN
      FIX: begin
        quot_d  = qneg_q ? -qs_q : qs_q;
        rem_d   = rneg_q ? -r_q[LENGTH-1:0] : r_q[LENGTH-1:0];
        state_d = DONE;
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      dl_q    <= '0;
      dvs_q   <= '0;
      qs_q    <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      dl_q    <= dl_d;
      dvs_q   <= dvs_d;
      qs_q    <= qs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
`ifdef SEQ_DIV_SIGNED_EN
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider at LENGTH=16.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
`ifdef SEQ_DIV_SIGNED_EN
  logic        signed_op;
`endif
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        dbz;
  logic        ovf;

  int total;
  int bad;

  seq_divider #(.LENGTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef SEQ_DIV_SIGNED_EN
    .signed_op (signed_op),
`endif
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and return the cycle in which done was seen (start edge = cycle 0).
  task automatic run_op(input logic [31:0] a, input logic [15:0] b, output int cyc);
    tick();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    total++; if (quotient !== 16'h0) begin bad++; $display("FAIL reset_quot got=%h want=0000", quotient); end
    total++; if (remainder !== 16'h0) begin bad++; $display("FAIL reset_rem got=%h want=0000", remainder); end
    total++; if (dbz !== 1'b0)       begin bad++; $display("FAIL reset_dbz got=%0b want=0", dbz); end
    total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL reset_ovf got=%0b want=0", ovf); end
  endtask

  task automatic test_basic();
    int cyc;
    run_op(32'd1000, 16'd7, cyc);
    total++; if (cyc !== 17)          begin bad++; $display("FAIL basic_latency got=%0d want=17", cyc); end
    total++; if (quotient !== 16'd142) begin bad++; $display("FAIL basic_quot got=%0d want=142", quotient); end
    total++; if (remainder !== 16'd6) begin bad++; $display("FAIL basic_rem got=%0d want=6", remainder); end
    total++; if ({dbz, ovf} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b want=00", {dbz, ovf}); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%0b want=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%0b want=0", busy); end
    total++; if (quotient !== 16'd142) begin bad++; $display("FAIL basic_hold got=%0d want=142", quotient); end
  endtask

  task automatic test_dbz();
    int cyc;
    run_op(32'd12345, 16'd0, cyc);
    total++; if (cyc !== 1)             begin bad++; $display("FAIL dbz_latency got=%0d want=1", cyc); end
    total++; if (dbz !== 1'b1)          begin bad++; $display("FAIL dbz_flag got=%0b want=1", dbz); end
    total++; if (ovf !== 1'b0)          begin bad++; $display("FAIL dbz_ovf got=%0b want=0", ovf); end
    total++; if (quotient !== 16'hFFFF) begin bad++; $display("FAIL dbz_quot got=%h want=ffff", quotient); end
    total++; if (remainder !== 16'h0)   begin bad++; $display("FAIL dbz_rem got=%h want=0000", remainder); end
  endtask

  task automatic test_ovf();
    int cyc;
    run_op(32'h0001_0000, 16'h0001, cyc);
    total++; if (cyc !== 1)             begin bad++; $display("FAIL ovf_latency got=%0d want=1", cyc); end
    total++; if (ovf !== 1'b1)          begin bad++; $display("FAIL ovf_flag got=%0b want=1", ovf); end
    total++; if (dbz !== 1'b0)          begin bad++; $display("FAIL ovf_dbz got=%0b want=0", dbz); end
    total++; if (quotient !== 16'hFFFF) begin bad++; $display("FAIL ovf_quot got=%h want=ffff", quotient); end
    total++; if (remainder !== 16'h0)   begin bad++; $display("FAIL ovf_rem got=%h want=0000", remainder); end
  endtask

  task automatic test_max();
    int cyc;
    run_op(32'hFFFE_0001, 16'hFFFF, cyc);
    total++; if (cyc !== 17)            begin bad++; $display("FAIL max_latency got=%0d want=17", cyc); end
    total++; if (quotient !== 16'hFFFF) begin bad++; $display("FAIL max_quot got=%h want=ffff", quotient); end
    total++; if (remainder !== 16'h0)   begin bad++; $display("FAIL max_rem got=%h want=0000", remainder); end
    total++; if ({dbz, ovf} !== 2'b00)  begin bad++; $display("FAIL max_flags got=%b want=00", {dbz, ovf}); end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    tick();
    dividend = 32'd1000;
    divisor  = 16'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    repeat (3) begin tick(); cyc++; end
    // Mid-run request with different operands must be dropped.
    dividend = 32'd9;
    divisor  = 16'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc++;
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL ignore_busy got=%b want=10", {busy, done}); end
    while (done !== 1'b1 && cyc < 60) begin tick(); cyc++; end
    total++; if (cyc !== 17)           begin bad++; $display("FAIL ignore_latency got=%0d want=17", cyc); end
    total++; if (quotient !== 16'd142) begin bad++; $display("FAIL ignore_quot got=%0d want=142", quotient); end
    total++; if (remainder !== 16'd6)  begin bad++; $display("FAIL ignore_rem got=%0d want=6", remainder); end
    // Request raised during the done cycle must also be dropped.
    dividend = 32'd40;
    divisor  = 16'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL done_start_busy got=%b want=00", {busy, done}); end
    total++; if (quotient !== 16'd142)   begin bad++; $display("FAIL done_start_quot got=%0d want=142", quotient); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    tick();
    dividend = 32'd1000;
    divisor  = 16'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    // Now in cycle 8 of the operation.
    rst_n = 1'b0;
    #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midrst_ctrl got=%b want=00", {busy, done}); end
    total++; if (quotient !== 16'h0)     begin bad++; $display("FAIL midrst_quot got=%h want=0000", quotient); end
    total++; if (remainder !== 16'h0)    begin bad++; $display("FAIL midrst_rem got=%h want=0000", remainder); end
    total++; if ({dbz, ovf} !== 2'b00)   begin bad++; $display("FAIL midrst_flags got=%b want=00", {dbz, ovf}); end
    tick();
    rst_n = 1'b1;
    run_op(32'd50000, 16'd250, cyc);
    total++; if (cyc !== 17)           begin bad++; $display("FAIL postrst_latency got=%0d want=17", cyc); end
    total++; if (quotient !== 16'd200) begin bad++; $display("FAIL postrst_quot got=%0d want=200", quotient); end
    total++; if (remainder !== 16'd0)  begin bad++; $display("FAIL postrst_rem got=%0d want=0", remainder); end
  endtask

  task automatic test_random();
    int          cyc;
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    for (int i = 0; i < 24; i++) begin
      b = 16'($urandom_range(0, 65535));
      if (i % 8 == 0) b = 16'($urandom_range(0, 3));
      if (i % 3 == 0 && b != 16'h0) a = {16'($urandom_range(0, int'(b) - 1)), 16'($urandom)};
      else a = $urandom;
      run_op(a, b, cyc);
      if (b == 16'h0) begin
        total++; if ({dbz, ovf, quotient, remainder} !== {2'b10, 16'hFFFF, 16'h0} || cyc !== 1) begin
          bad++; $display("FAIL rand_dbz a=%h b=%h got dbz=%0b ovf=%0b q=%h r=%h cyc=%0d", a, b, dbz, ovf, quotient, remainder, cyc);
        end
      end else if (a[31:16] >= b) begin
        total++; if ({dbz, ovf, quotient, remainder} !== {2'b01, 16'hFFFF, 16'h0} || cyc !== 1) begin
          bad++; $display("FAIL rand_ovf a=%h b=%h got dbz=%0b ovf=%0b q=%h r=%h cyc=%0d", a, b, dbz, ovf, quotient, remainder, cyc);
        end
      end else begin
        eq = a / {16'h0, b};
        er = a % {16'h0, b};
        total++; if ({dbz, ovf, quotient, remainder} !== {2'b00, eq[15:0], er[15:0]} || cyc !== 17) begin
          bad++; $display("FAIL rand_div a=%h b=%h got q=%h r=%h flags=%b cyc=%0d want q=%h r=%h", a, b, quotient, remainder, {dbz, ovf}, cyc, eq[15:0], er[15:0]);
        end
      end
    end
  endtask

`ifdef SEQ_DIV_SIGNED_EN
  task automatic test_signed();
    int cyc;
    signed_op = 1'b1;
    run_op(-32'sd1000, 16'd7, cyc);
    signed_op = 1'b0;
    total++; if (cyc !== 18)            begin bad++; $display("FAIL signed_latency got=%0d want=18", cyc); end
    total++; if (quotient !== 16'hFF72) begin bad++; $display("FAIL signed_quot got=%h want=ff72", quotient); end
    total++; if (remainder !== 16'hFFFA) begin bad++; $display("FAIL signed_rem got=%h want=fffa", remainder); end
    total++; if ({dbz, ovf} !== 2'b00)  begin bad++; $display("FAIL signed_flags got=%b want=00", {dbz, ovf}); end
  endtask
`endif

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 32'h0;
    divisor  = 16'h0;
`ifdef SEQ_DIV_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_dbz();
    test_ovf();
    test_max();
    test_busy_ignore();
    test_reset_mid_run();
    test_random();
`ifdef SEQ_DIV_SIGNED_EN
    test_signed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
